// File: rtl/mul_pkg.sv
// Shared constants and types for the execute-stage arithmetic units (multiply now, divide later).
package mul_pkg;

  localparam int MUL_WIDTH = 32;

  // Iteration counter must be able to hold WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int MUL_CNT_W = cnt_width(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally add (or subtract) the multiplicand, then shift acc:mult right by one.
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mult,
  input  logic [WIDTH:0]   mcand,
  input  logic             sub,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] mult_next
);

  logic [WIDTH+1:0] addend;
  logic [WIDTH+1:0] sum;

  // One guard bit above the sign-extended accumulator keeps add/subtract exact.
  always_comb begin
    addend = mult[0] ? {mcand[WIDTH], mcand} : '0;
    if (sub) begin
      sum = {acc[WIDTH], acc} - addend;
    end else begin
      sum = {acc[WIDTH], acc} + addend;
    end
    acc_next  = sum[WIDTH+1:1];
    mult_next = {sum[0], mult[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_multiply.sv
// Multi-cycle WIDTHxWIDTH multiplier, one multiplier bit per clock, signed or unsigned.
// Optional MUL_OVERFLOW_FLAG_EN adds an ovf output registered alongside hi/lo.
// Handshake: start is sampled only in IDLE or DONE; busy is high for exactly WIDTH cycles,
// then done pulses for one cycle with hi/lo valid; start during RUN is dropped.
module seq_multiply
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
`ifdef MUL_OVERFLOW_FLAG_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = cnt_width(WIDTH);

  mul_state_t state;
  mul_state_t state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mult;
  logic [WIDTH:0]   mcand;
  logic             signed_q;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] mult_next;
  logic             last;
  logic             accept;

  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // The multiplier's top bit carries weight -2^(WIDTH-1) in signed mode, so the last step subtracts.
  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mult     (mult),
    .mcand    (mcand),
    .sub      (signed_q && last),
    .acc_next (acc_next),
    .mult_next(mult_next)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      mult     <= '0;
      mcand    <= '0;
      signed_q <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MUL_OVERFLOW_FLAG_EN
      ovf      <= 1'b0;
`endif
    end else if (accept) begin
      cnt      <= '0;
      acc      <= '0;
      mult     <= B;
      mcand    <= {is_signed & A[WIDTH-1], A};
      signed_q <= is_signed;
    end else if (state == RUN) begin
      acc  <= acc_next;
      mult <= mult_next;
      cnt  <= cnt + CNT_W'(1);
      if (last) begin
        hi <= acc_next[WIDTH-1:0];
        lo <= mult_next;
`ifdef MUL_OVERFLOW_FLAG_EN
        ovf <= signed_q ? (acc_next[WIDTH-1:0] != {WIDTH{mult_next[WIDTH-1]}})
                        : (acc_next[WIDTH-1:0] != '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_multiply.sv
// Scoreboard bench for seq_multiply: directed vectors, latency, hold, back-to-back, ignored start, async reset.
module tb_seq_multiply;
  import mul_pkg::*;

  localparam int W = MUL_WIDTH;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] h;
    logic [W-1:0] l;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef MUL_OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  logic [2*W:0] exp_q[$];
  int           exp_cyc_q[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  vec_t         vecs[16];

  seq_multiply #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_signed(is_signed),
    .A        (a),
    .B        (b),
    .busy     (busy),
    .done     (done),
`ifdef MUL_OVERFLOW_FLAG_EN
    .ovf      (ovf),
`endif
    .hi       (hi),
    .lo       (lo)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
    end
  endtask

  function automatic logic [2*W:0] pack_exp(input logic s, input logic [W-1:0] h, input logic [W-1:0] l);
    logic f;
    f = s ? (h != {W{l[W-1]}}) : (h != '0);
    return {f, h, l};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue_now(input logic s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
    start     = 1'b1;
    is_signed = s;
    a         = ia;
    b         = ib;
    exp_q.push_back(pack_exp(s, eh, el));
    exp_cyc_q.push_back(cyc + 1 + W);
    @(negedge clk);
    start     = 1'b0;
    is_signed = ~s;
    a         = $urandom;
    b         = $urandom;
  endtask

  task automatic issue(input logic s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] eh, input logic [W-1:0] el);
    @(negedge clk);
    issue_now(s, ia, ib, eh, el);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 2*W'(exp_q.size()), '0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [2*W:0] e;
    int           c;
    if (!reset) begin
      check("busy_and_done", 2*W'(busy & done), '0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 2*W'(1), '0);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("product", {hi, lo}, e[2*W-1:0]);
          check("done_cycle", 2*W'(cyc), 2*W'(c));
`ifdef MUL_OVERFLOW_FLAG_EN
          check("ovf", 2*W'(ovf), 2*W'(e[2*W]));
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vecs = '{
      '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
      '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001},
      '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
      '{1'b1, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
      '{1'b0, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A},
      '{1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000},
      '{1'b1, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000},
      '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
      '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000},
      '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
      '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000},
      '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001},
      '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE},
      '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000},
      '{1'b1, 32'h0000_0003, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFEB}
    };

    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 2*W'(busy), '0);
    check("reset_done", 2*W'(done), '0);
    check("reset_hilo", {hi, lo}, '0);
    reset = 1'b0;

    // Directed table, one operation at a time.
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].l);
      wait_drain();
    end

    // hi/lo hold the previous result (last table entry) through the next run; a start in RUN is dropped.
    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    repeat (8) @(negedge clk);
    check("busy_in_run", 2*W'(busy), 2*W'(1));
    check("hold_prev_result", {hi, lo}, {vecs[15].h, vecs[15].l});
    start = 1'b1;
    is_signed = 1'b1;
    a = 32'h0000_0005;
    b = 32'h0000_0003;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Back-to-back: new start accepted during the DONE cycle.
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    begin
      int n;
      n = 0;
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("b2b_first_done_seen", 2*W'(done), 2*W'(1));
    end
    issue_now(1'b0, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A);
    check("b2b_busy_next", 2*W'(busy), 2*W'(1));
    repeat (5) @(negedge clk);
    check("b2b_hold_first", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    wait_drain();

    // Async reset in the middle of a run abandons it with no done pulse.
    issue(1'b0, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 32'hA3D7_0A38);
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_busy", 2*W'(busy), '0);
    check("midrun_reset_done", 2*W'(done), '0);
    check("midrun_reset_hilo", {hi, lo}, '0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(1'b0, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
